// File: rtl/uart8_tx_fifo.sv
// Byte FIFO plus issue FSM feeding an 8-bit UART transmitter in the baud clock domain.
// A byte leaves the FIFO only after the transmitter has been seen busy with it.
module uart8_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WD_CYCLES  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  wr_valid_i,
  input  logic [7:0]            wr_data_i,
  output logic                  wr_ready_o,
  output logic                  tx_valid_o,
  output logic [7:0]            tx_data_o,
  input  logic                  tx_ready_i,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  busy_o
);

  localparam int unsigned          DEPTH    = 2 ** DEPTH_LOG2;
  localparam int unsigned          WD_W     = $clog2(WD_CYCLES + 1);
  localparam logic [DEPTH_LOG2:0]  FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [WD_W-1:0]      WD_LAST  = WD_W'(WD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    count_q, count_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   wr_en;
  logic                   commit;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign wr_ready_o = ~full_o;
  assign busy_o     = (state_q != S_IDLE);
  assign count_o    = count_q;
  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;

  // A commit in the same cycle does not open a slot: wr_ready is purely ~full.
  assign wr_en    = wr_valid_i & ~full_o;
  assign wr_ptr_d = wr_en  ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = commit ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_comb begin
    count_d = count_q;
    case ({wr_en, commit})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is deliberately left out of reset; only pointers and count qualify its contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first, so no branch can leave a latch behind.
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    wd_d       = wd_q;
    commit     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_i && !empty_o && tx_ready_i) begin
          tx_data_d  = mem_q[rd_ptr_q];
          tx_valid_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tx_valid_d = 1'b0;
        wd_d       = '0;
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // tx_ready falling proves the transmitter took the byte; only then is it dropped.
        if (!tx_ready_i) begin
          commit  = 1'b1;
          state_d = S_WAIT_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
          if (wd_q == WD_LAST) begin
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (tx_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wd_q       <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wd_q       <= wd_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_uart8_tx_fifo.sv
// Bench for uart8_tx_fifo: a UART transmitter model, a queue-based FIFO reference
// and a per-cycle comparison, plus directed scenarios with literal expectations.
module tb_uart8_tx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int WD_CYCLES  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, tx_valid, empty, full, busy;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [4:0] count;

  always #5 clk = ~clk;

  uart8_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WD_CYCLES(WD_CYCLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .wr_valid_i (wr_valid),
    .wr_data_i  (wr_data),
    .wr_ready_o (wr_ready),
    .tx_valid_o (tx_valid),
    .tx_data_o  (tx_data),
    .tx_ready_i (tx_ready),
    .count_o    (count),
    .empty_o    (empty),
    .full_o     (full),
    .busy_o     (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- transmitter model ----------------
  // Idle: ready=1. On accept, ready stays high one more cycle, then low for 10 bit times.
  logic        ign_mode = 1'b0;
  logic        tx_hold;
  int          tx_bits;
  logic [9:0]  tx_sh;
  logic [9:0]  rx_frame;
  logic [9:0]  last_frame;
  logic [9:0]  f;
  logic [31:0] exp_b;
  byte unsigned exp_sent[$];
  byte unsigned rx_log[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready <= 1'b1;
      tx_hold  <= 1'b0;
      tx_bits  <= 0;
      tx_sh    <= '0;
    end else if (tx_hold) begin
      tx_hold  <= 1'b0;
      tx_ready <= 1'b0;
      tx_bits  <= 10;
    end else if (tx_bits > 0) begin
      f = rx_frame;
      f[10 - tx_bits] = tx_sh[0];
      rx_frame <= f;
      tx_sh    <= tx_sh >> 1;
      tx_bits  <= tx_bits - 1;
      if (tx_bits == 1) begin
        tx_ready   <= 1'b1;
        last_frame <= f;
        check("rx_framing", {30'd0, f[9], f[0]}, 32'd2);
        rx_log.push_back(f[8:1]);
        exp_b = (exp_sent.size() > 0) ? {24'd0, exp_sent.pop_front()} : 32'hFFFF_FFFF;
        check("rx_order", {24'd0, f[8:1]}, exp_b);
      end
    end else if (!ign_mode && en && tx_valid && tx_ready) begin
      tx_sh   <= {1'b1, tx_data, 1'b0};
      tx_hold <= 1'b1;
    end
  end

  // ---------------- FIFO reference model ----------------
  // Queue of held bytes; m_phase: 0 idle, 1 just issued, 2..WD+1 waiting for busy, -1 waiting for done.
  byte unsigned mq[$];
  logic        m_valid;
  logic [7:0]  m_data;
  int          m_phase;
  int          m_accepted = 0;
  bit          m_push, m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_sent.delete();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_phase = 0;
    end else begin
      m_push = wr_valid && (mq.size() < DEPTH);
      m_pop  = 1'b0;
      if (m_phase == 0) begin
        if (en && mq.size() > 0 && tx_ready) begin
          m_data  = mq[0];
          m_valid = 1'b1;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_valid = 1'b0;
        m_phase = 2;
      end else if (m_phase == -1) begin
        if (tx_ready) m_phase = 0;
      end else begin
        if (!tx_ready) begin
          m_pop   = 1'b1;
          m_phase = -1;
        end else if (m_phase == WD_CYCLES + 1) begin
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back(wr_data);
        exp_sent.push_back(wr_data);
        m_accepted++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int cyc = 0;
  int valid_cycles = 0;
  int pulses[$];
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    check("cycle", 32'({count, empty, full, wr_ready, busy, tx_valid, tx_data}),
          32'({5'(mq.size()), mq.size() == 0, mq.size() == DEPTH, mq.size() != DEPTH,
               m_phase != 0, m_valid, m_data}));
    if (tx_valid && !ign_mode)
      check("issue_window", {30'd0, tx_hold, tx_bits != 0}, 32'd0);
    if (tx_valid) valid_cycles++;
    if (tx_valid && !prev_valid) pulses.push_back(cyc);
    prev_valid = tx_valid;
  end

  // ---------------- helpers ----------------
  task automatic drive_write(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    logic done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (mq.size() == 0) && (m_phase == 0) && !tx_hold && (tx_bits == 0);
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int base;
    int start;
    logic found;

    repeat (2) @(negedge clk);
    check("reset_state", {22'd0, count, tx_valid, busy, empty, tx_data == 8'h00, wr_ready},
          {22'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single byte, idle transmitter
    en = 1'b1;
    valid_cycles = 0;
    base = rx_log.size();
    drive_write(8'h55);
    wait_drain("t1_drain", 200);
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_frame", {22'd0, last_frame}, 32'h2AA);
    check("t1_rx_count", rx_log.size() - base, 1);
    check("t1_count", {27'd0, count}, 0);

    // 2: fill while disabled, overflow write ignored, drain in order
    en = 1'b0;
    base = rx_log.size();
    for (int i = 1; i <= 16; i++) drive_write(8'(i));
    drive_write(8'hAA);
    check("t2_full", {30'd0, full, wr_ready}, 32'd2);
    check("t2_count", {27'd0, count}, 16);
    en = 1'b1;
    wait_drain("t2_drain", 400);
    check("t2_rx_count", rx_log.size() - base, 16);
    check("t2_first", {24'd0, rx_log[base]}, 32'h01);
    check("t2_last", {24'd0, rx_log[base + 15]}, 32'h10);

    // 3: held while en=0, sent once after enable
    en = 1'b0;
    valid_cycles = 0;
    base = rx_log.size();
    drive_write(8'h3C);
    repeat (10) @(negedge clk);
    check("t3_no_valid", valid_cycles, 0);
    check("t3_count", {27'd0, count}, 1);
    en = 1'b1;
    wait_drain("t3_drain", 100);
    check("t3_rx_count", rx_log.size() - base, 1);

    // 4: transmitter ignores valid -> periodic re-issue, then released
    ign_mode = 1'b1;
    pulses.delete();
    base = rx_log.size();
    drive_write(8'h3C);
    repeat (25) @(negedge clk);
    check("t4_count", {27'd0, count}, 1);
    check("t4_pulses", {31'd0, pulses.size() >= 4}, 32'd1);
    for (int i = 1; i < pulses.size(); i++)
      check("t4_period", pulses[i] - pulses[i - 1], 5);
    ign_mode = 1'b0;
    wait_drain("t4_drain", 100);
    check("t4_rx_count", rx_log.size() - base, 1);
    check("t4_byte", {24'd0, rx_log[base]}, 32'h3C);

    // 5: async reset while waiting for the transmitter to finish, 5 bytes held
    for (int i = 0; i < 6; i++) drive_write(8'hC0 + 8'(i));
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      found = (m_phase == -1) && (mq.size() == 5);
      if (!found) @(negedge clk);
    end
    check("t5_reach_wait_done", {31'd0, found}, 32'd1);
    check("t5_pre", {26'd0, count, busy}, {26'd0, 5'd5, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    check("t5_count", {27'd0, count}, 0);
    check("t5_flags", {28'd0, tx_valid, busy, empty, wr_ready}, 32'b0011);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 6: random streaming with en jitter, 40 bytes through a wrapping FIFO
    base  = rx_log.size();
    start = m_accepted;
    for (int i = 0; i < 4000 && m_accepted < start + 40; i++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = 8'($urandom);
      en       = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      check("t6_count_bound", {31'd0, count <= 5'd16}, 32'd1);
    end
    wr_valid = 1'b0;
    en = 1'b1;
    check("t6_accepted", m_accepted - start, 40);
    wait_drain("t6_drain", 1000);
    check("t6_rx_count", rx_log.size() - base, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
